// File: rtl/fp_to_int_seq_if.sv
// Valid/ready bus of the iterative float-to-int converter.
// The converter sits on the slave modport and its producer/consumer on the master modport.
interface fp_to_int_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_exception;
  logic        out_zero;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_exception,
    input  out_zero
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_exception,
    output out_zero
  );
endinterface

// File: rtl/fp_to_int_seq.sv
// Iterative IEEE-754 single to signed 32-bit integer converter with a multi-cycle aligner.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; the default truncates toward zero.
module fp_to_int_seq #(
  parameter int SHIFT_STEP = 1
) (
  input  logic           clk,
  input  logic           rst,
  fp_to_int_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        exc_q, exc_d;
  logic        zero_q, zero_d;
`ifdef FP2INT_ROUND_NEAREST_EN
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic        round_up;
`endif

  logic              in_sign;
  logic [7:0]        in_exp;
  logic [22:0]       in_frac;
  logic [23:0]       in_mant;
  logic signed [9:0] e;
  logic              is_nan;
  logic              too_big;
  logic              too_small;
  logic              go_left;
  logic [4:0]        cnt_load;
  logic [4:0]        amt;
  logic [31:0]       mag;
  logic [31:0]       res;

  assign in_sign = bus.in_data[31];
  assign in_exp  = bus.in_data[30:23];
  assign in_frac = bus.in_data[22:0];
  assign in_mant = {(in_exp != 8'd0), in_frac};
  assign e       = $signed({2'b00, in_exp}) - 10'sd127;
  assign is_nan  = (in_exp == 8'hFF) && (in_frac != 23'd0);

  // -2^31 is the one e==31 value that still fits the integer range
  assign too_big = (e >= 10'sd31) && !(in_sign && (in_exp == 8'd158) && (in_frac == 23'd0));

`ifdef FP2INT_ROUND_NEAREST_EN
  assign too_small = (e < -10'sd1);
`else
  assign too_small = (e < 10'sd0);
`endif

  // Alignment distance is at most 24, so 5-bit modular arithmetic on e is exact
  assign go_left  = (e >= 10'sd23);
  assign cnt_load = go_left ? (e[4:0] - 5'd23) : (5'd23 - e[4:0]);

  assign bus.in_ready      = (state_q == IDLE) && !rst;
  assign bus.out_valid     = valid_q;
  assign bus.out_data      = data_q;
  assign bus.out_exception = exc_q;
  assign bus.out_zero      = zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      left_q   <= 1'b0;
      sign_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      exc_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef FP2INT_ROUND_NEAREST_EN
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      left_q   <= left_d;
      sign_q   <= sign_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      exc_q    <= exc_d;
      zero_q   <= zero_d;
`ifdef FP2INT_ROUND_NEAREST_EN
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    left_d   = left_q;
    sign_d   = sign_q;
    valid_d  = valid_q;
    data_d   = data_q;
    exc_d    = exc_q;
    zero_d   = zero_q;
    amt      = 5'd0;
    mag      = shreg_q;
    res      = 32'd0;
`ifdef FP2INT_ROUND_NEAREST_EN
    guard_d  = guard_q;
    sticky_d = sticky_q;
    round_up = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = in_sign;
          if ((in_exp == 8'hFF) || too_big) begin
            state_d = DONE;
            valid_d = 1'b1;
            exc_d   = 1'b1;
            zero_d  = 1'b0;
            data_d  = (is_nan || !in_sign) ? 32'h7FFF_FFFF : 32'h8000_0000;
          end else if (too_small) begin
            state_d = DONE;
            valid_d = 1'b1;
            exc_d   = 1'b0;
            zero_d  = 1'b1;
            data_d  = 32'd0;
          end else begin
            state_d  = SHIFT;
            shreg_d  = {8'h00, in_mant};
            left_d   = go_left;
            cnt_d    = cnt_load;
`ifdef FP2INT_ROUND_NEAREST_EN
            guard_d  = 1'b0;
            sticky_d = 1'b0;
`endif
          end
        end
      end

      // Unrolled single-bit steps keep guard/sticky tracking identical for any step size
      SHIFT: begin
        if (cnt_q == 5'd0) begin
          state_d = FIX;
        end else begin
          amt = (cnt_q < STEP) ? cnt_q : STEP;
          for (int i = 0; i < SHIFT_STEP; i++) begin
            if (5'(i) < amt) begin
              if (left_q) begin
                shreg_d = shreg_d << 1;
              end else begin
`ifdef FP2INT_ROUND_NEAREST_EN
                sticky_d = sticky_d | guard_d;
                guard_d  = shreg_d[0];
`endif
                shreg_d = shreg_d >> 1;
              end
            end
          end
          cnt_d = cnt_q - amt;
        end
      end

      FIX: begin
`ifdef FP2INT_ROUND_NEAREST_EN
        round_up = guard_q && (sticky_q || shreg_q[0]);
        mag      = shreg_q + {31'd0, round_up};
`else
        mag      = shreg_q;
`endif
        res     = sign_q ? (~mag + 32'd1) : mag;
        data_d  = res;
        zero_d  = (res == 32'd0);
        exc_d   = 1'b0;
        valid_d = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Directed bench for fp_to_int_seq with one SHIFT_STEP=1 and one SHIFT_STEP=8 instance.
// Expected results follow FP2INT_ROUND_NEAREST_EN when the bench is built with it.
module tb_fp_to_int_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel8;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fp_to_int_seq_if bus1 ();
  fp_to_int_seq_if bus8 ();

  assign bus1.in_valid  = in_valid && !sel8;
  assign bus8.in_valid  = in_valid && sel8;
  assign bus1.in_data   = in_data;
  assign bus8.in_data   = in_data;
  assign bus1.out_ready = out_ready && !sel8;
  assign bus8.out_ready = out_ready && sel8;

  logic        obs_in_ready;
  logic        obs_out_valid;
  logic [31:0] obs_out_data;
  logic        obs_out_exc;
  logic        obs_out_zero;

  assign obs_in_ready  = sel8 ? bus8.in_ready      : bus1.in_ready;
  assign obs_out_valid = sel8 ? bus8.out_valid     : bus1.out_valid;
  assign obs_out_data  = sel8 ? bus8.out_data      : bus1.out_data;
  assign obs_out_exc   = sel8 ? bus8.out_exception : bus1.out_exception;
  assign obs_out_zero  = sel8 ? bus8.out_zero      : bus1.out_zero;

  fp_to_int_seq #(.SHIFT_STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fp_to_int_seq #(.SHIFT_STEP(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Transfer one word and return how many clock edges until out_valid is seen
  task automatic sendWord(input logic [31:0] data, output int lat);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!obs_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    in_data  = data;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!obs_out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic acceptResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "/valid_drop"}, 32'(obs_out_valid), 32'd0);
    checkOutput({tag, "/in_ready"}, 32'(obs_in_ready), 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] data, input int exp_lat,
                               input logic [31:0] exp_data, input logic exp_exc, input logic exp_zero);
    int lat;
    sendWord(data, lat);
    checkOutput({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "/valid"}, 32'(obs_out_valid), 32'd1);
    checkOutput({tag, "/data"}, obs_out_data, exp_data);
    checkOutput({tag, "/exception"}, 32'(obs_out_exc), 32'(exp_exc));
    checkOutput({tag, "/zero"}, 32'(obs_out_zero), 32'(exp_zero));
    acceptResult(tag);
  endtask

  initial begin
    int  lat;
    logic seen;
    rst       = 1'b1;
    sel8      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset/valid", 32'(obs_out_valid), 32'd0);
    checkOutput("reset/data", obs_out_data, 32'd0);
    checkOutput("reset/exception", 32'(obs_out_exc), 32'd0);
    checkOutput("reset/zero", 32'(obs_out_zero), 32'd0);
    checkOutput("reset/in_ready_low", 32'(obs_in_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset/in_ready_high", 32'(obs_in_ready), 32'd1);

    applyStimulus("one",       32'h3F80_0000, 26, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus("m123",      32'hC2F6_0000, 20, 32'hFFFF_FF85, 1'b0, 1'b0);
    applyStimulus("min_int",   32'hCF00_0000, 11, 32'h8000_0000, 1'b0, 1'b0);
    applyStimulus("near_max",  32'h4EFF_FFFF, 10, 32'h7FFF_FF80, 1'b0, 1'b0);
    applyStimulus("pos_2p31",  32'h4F00_0000,  1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    applyStimulus("pos_inf",   32'h7F80_0000,  1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    applyStimulus("neg_inf",   32'hFF80_0000,  1, 32'h8000_0000, 1'b1, 1'b0);
    applyStimulus("nan",       32'h7FC0_0000,  1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    applyStimulus("zero",      32'h0000_0000,  1, 32'h0000_0000, 1'b0, 1'b1);
    applyStimulus("denormal",  32'h0040_0000,  1, 32'h0000_0000, 1'b0, 1'b1);
`ifdef FP2INT_ROUND_NEAREST_EN
    applyStimulus("half",      32'h3F00_0000, 27, 32'h0000_0000, 1'b0, 1'b1);
    applyStimulus("m_almost1", 32'hBF7F_FFFF, 27, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("p0_75",     32'h3F40_0000, 27, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus("p1_5",      32'h3FC0_0000, 26, 32'h0000_0002, 1'b0, 1'b0);
    applyStimulus("p2_5",      32'h4020_0000, 25, 32'h0000_0002, 1'b0, 1'b0);
    applyStimulus("m3_5",      32'hC060_0000, 25, 32'hFFFF_FFFC, 1'b0, 1'b0);
`else
    applyStimulus("half",      32'h3F00_0000,  1, 32'h0000_0000, 1'b0, 1'b1);
    applyStimulus("m_almost1", 32'hBF7F_FFFF,  1, 32'h0000_0000, 1'b0, 1'b1);
    applyStimulus("p0_75",     32'h3F40_0000,  1, 32'h0000_0000, 1'b0, 1'b1);
    applyStimulus("p1_5",      32'h3FC0_0000, 26, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus("p2_5",      32'h4020_0000, 25, 32'h0000_0002, 1'b0, 1'b0);
    applyStimulus("m3_5",      32'hC060_0000, 25, 32'hFFFF_FFFD, 1'b0, 1'b0);
`endif

    // Backpressure: result must hold and a stray input must be ignored
    sendWord(32'h4120_0000, lat);
    checkOutput("bp/latency", 32'(lat), 32'd23);
    checkOutput("bp/data", obs_out_data, 32'd10);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1);
      in_data  = 32'h4000_0000;
      @(posedge clk);
      #1;
      checkOutput("bp/hold_valid", 32'(obs_out_valid), 32'd1);
      checkOutput("bp/hold_data", obs_out_data, 32'd10);
      checkOutput("bp/hold_exception", 32'(obs_out_exc), 32'd0);
      checkOutput("bp/hold_zero", 32'(obs_out_zero), 32'd0);
      checkOutput("bp/hold_in_ready", 32'(obs_in_ready), 32'd0);
    end
    in_valid = 1'b0;
    acceptResult("bp");
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      seen = seen | obs_out_valid;
    end
    checkOutput("bp/stray_ignored", 32'(seen), 32'd0);

    // Reset in the middle of SHIFT discards the conversion
    @(negedge clk);
    in_data  = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid/valid", 32'(obs_out_valid), 32'd0);
    checkOutput("rst_mid/data", obs_out_data, 32'd0);
    checkOutput("rst_mid/exception", 32'(obs_out_exc), 32'd0);
    checkOutput("rst_mid/zero", 32'(obs_out_zero), 32'd0);
    checkOutput("rst_mid/in_ready", 32'(obs_in_ready), 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      seen = seen | obs_out_valid;
    end
    checkOutput("rst_mid/discarded", 32'(seen), 32'd0);

    sel8 = 1'b1;
    applyStimulus("s8_one",     32'h3F80_0000, 6, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus("s8_m123",    32'hC2F6_0000, 6, 32'hFFFF_FF85, 1'b0, 1'b0);
    applyStimulus("s8_min_int", 32'hCF00_0000, 4, 32'h8000_0000, 1'b0, 1'b0);
    applyStimulus("s8_pos_inf", 32'h7F80_0000, 1, 32'h7FFF_FFFF, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fp_to_int_seq.md
Name: fp_to_int_seq

Overview:
- Iterative single-precision float to signed 32-bit integer converter.
- It is the consuming end of the FP add/sub datapath: it unpacks and denormalises an IEEE-754 word, which is the inverse of that datapath's leading-one normalise/pack step.
- Valid/ready handshakes on input and output. Alignment is done by a multi-cycle shifter, trading latency for area.
- Conventions shared with the add/sub unit:
  - exponent 255 flags exception;
  - exponent 0 has hidden bit 0 (denormals flush to zero).

Parameters:
- SHIFT_STEP, 1, maximum bit positions shifted per SHIFT cycle. Legal values: 1, 2, 4, 8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  converter can accept; high only in IDLE and not in reset
- in_data  input  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  downstream accepts the result
- out_data  output  32  two's-complement integer result
- out_exception  output  1  Inf/NaN/overflow; out_data is saturated
- out_zero  output  1  out_data == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_exception=0, out_zero=0, state=IDLE, shift counter=0.
- States: IDLE, SHIFT, FIX, DONE.
- IDLE:
  - Transfer occurs when in_valid && in_ready at cycle T.
  - Compute e = exp - 127 and mant = {exp!=0, frac}.
- IDLE fast path (next state DONE, out_valid high at T+1):
  - exp==255, or e>=31 except exactly sign=1, exp=158, frac=0: out_exception=1.
    - NaN (frac!=0) or positive: out_data=0x7FFFFFFF.
    - Negative non-NaN: out_data=0x80000000.
  - e<0 (includes exp==0): out_data=0, out_zero=1, out_exception=0.
- IDLE normal path: load 32-bit shift register with mant, direction = left if e>=23 else right, n = |e-23| (0..23), then go to SHIFT.
- SHIFT:
  - Each cycle, shift by min(SHIFT_STEP, cnt) and decrement cnt by the same amount.
  - When cnt==0 at cycle entry, go to FIX.
- FIX:
  - out_data = sign ? -reg : reg; out_zero = (out_data==0); out_exception=0.
  - Go to DONE.
- DONE:
  - out_valid=1; out_data and flags are stable.
  - On out_valid && out_ready: out_valid=0 and go to IDLE.
  - The earliest next accept is the cycle after the handshake (no same-cycle turnaround).
- Latency, normal path: out_valid first high at T+3+ceil(n/SHIFT_STEP).
- Width rules:
  - Maximum left shift is 8 (e=31, the -2^31 case only); the register holds 0x80000000 and negation leaves 0x80000000.
  - Right-shifted bits are discarded, i.e. truncation toward zero.
- in_valid while not in IDLE: ignored (in_ready=0). in_data is sampled only on transfer.
- out_ready while out_valid=0: ignored.
- rst in any state: the next state is IDLE with all outputs at reset values. An in-flight conversion is discarded and in_ready returns high the cycle after rst deasserts.

Optional Feature:
- Macro: FP2INT_ROUND_NEAREST_EN.
- Defined:
  - Round to nearest, ties to even.
  - Guard bit = last bit shifted out; sticky = OR of all earlier shifted-out bits.
  - e == -1 takes the normal path with n=24 (right shift) instead of the zero fast path.
  - FIX increments the magnitude when guard && (sticky || lsb), before applying the sign.
  - FIX still takes exactly one cycle.
  - Right-shifted results are < 2^24, so rounding cannot overflow.
- Undefined: truncation toward zero; no guard/sticky logic; e<0 always takes the fast path.

Test Plan:
- Basic, SHIFT_STEP=1: 0x3F800000 (1.0) -> out_data=0x00000001, flags 0, out_valid at T+26. 0xC2F60000 (-123.0) -> out_data=0xFFFFFF85, out_valid at T+20.
- Limits: 0xCF000000 -> out_data=0x80000000, out_exception=0. 0x4F000000 -> out_data=0x7FFFFFFF, out_exception=1 at T+1. 0x7F800000 -> 0x7FFFFFFF, exception. 0xFF800000 -> 0x80000000, exception. 0x7FC00000 -> 0x7FFFFFFF, exception.
- Zero and small values: 0x00000000, 0x00400000 (denormal), 0x3F000000 (0.5), 0xBF7FFFFF -> out_data=0, out_zero=1 at T+1, without the rounding macro.
- Rounding, macro defined: 0x3F000000 -> 0. 0x3F400000 (0.75) -> 1. 0x3FC00000 (1.5) -> 2. 0x40200000 (2.5) -> 2. 0xC0600000 (-3.5) -> 0xFFFFFFFC.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: out_data and flags stable, in_ready=0, and a pulse of in_valid with 0x40000000 is ignored. Then on out_ready=1: out_valid drops the next cycle and in_ready rises.
- Reset and SHIFT_STEP: assert rst for one cycle in the middle of SHIFT. Required: out_valid=0, outputs zero, in_ready=1 the cycle after deassert. Then 0x3F800000 with SHIFT_STEP=8 -> out_valid at T+6 with out_data=1.
